dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Word-addressed data memory with a request/acknowledge handshake that sits directly downstream of `alu_mem`. It accepts the LOAD/STORE request that `alu_mem` drives (`dmem_req_o`, `dmem_addr_o`, `dmem_we_o`, `dmem_wdata_o`). After a fixed, parameterised access latency it returns `dmem_rd_i` and `dmem_ack_i`. It models the processor's single-ported data RAM, including misaligned and out-of-range error reporting.

## Interface
- `DATA_WIDTH`, 32, data word width in bits
- `ADDR_WIDTH`, 32, byte-address width
- `DEPTH`, 256, number of words; power of two, ≥ 2
- `LATENCY`, 2, cycles from request acceptance to ack; ≥ 1
- `clk_i`  in  1  clock; all state changes on rising edge
- `arst_i`  in  1  reset, asynchronous, active-high
- `dmem_req_i`  in  1  request valid; held high until ack
- `dmem_addr_i`  in  ADDR_WIDTH  byte address
- `dmem_we_i`  in  1  1 = store, 0 = load
- `dmem_wdata_i`  in  DATA_WIDTH  store data
- `dmem_rdata_o`  out  DATA_WIDTH  load data; valid only while ack = 1
- `dmem_ack_o`  out  1  one-cycle completion pulse
- `dmem_err_o`  out  1  qualifies ack: access rejected (misaligned or out of range)

## Operation
- FSM states and transitions:
  - IDLE → BUSY on `dmem_req_i`, or directly to RESP when `LATENCY` = 1.
  - BUSY counts down `LATENCY-1` cycles, then → RESP.
  - RESP → IDLE.
- On acceptance (IDLE and req = 1), latch `addr`, `we` and `wdata`. Later changes on the inputs are ignored until ack.
- Word index = `addr[$clog2(DEPTH)+1:2]`.
- Error conditions:
  - misaligned: `addr[1:0]` ≠ 0;
  - out of range: any `addr` bit above `$clog2(DEPTH)+1` is set.
- On error: no write occurs, `rdata` = 0 and `err` = 1 during the ack cycle.
- Store:
  - The array is written at the rising edge that ends the RESP cycle (commit point).
  - `rdata` = 0 during the ack cycle.
- Load:
  - `rdata` = `mem[index]` during RESP; the array is read combinationally from the latched index.
  - A load issued after a store to the same word returns the new data.
- `dmem_ack_o` and `dmem_err_o` are high only in RESP.
- Memory contents are not cleared by reset. The bench writes before reading, or preloads via `$readmemh` in simulation only.

## Timing
- Reset values:
  - `dmem_ack_o` = 0, `dmem_err_o` = 0, `dmem_rdata_o` = 0;
  - FSM = IDLE, latency counter = 0.
- Latency: request accepted at edge N gives ack high in the cycle following edge N+`LATENCY`-1. Ack falls at edge N+`LATENCY`.
- Back-to-back: if req is still high in the IDLE cycle after RESP, the next request is accepted at that edge. Sustained throughput is one access per `LATENCY`+1 cycles.
- req dropping before ack is a protocol violation. The block ignores it and completes the latched access.
- Reset asserted mid-access:
  - The FSM returns to IDLE immediately and no ack is produced.
  - A store that has not passed its commit edge is not written.
- Reset released with req high: the request is accepted at the first rising edge after release.

## Structure
- `simple_processor_pkg` owns:
  - `DMEM_DEPTH` and `DMEM_LATENCY` defaults;
  - `typedef enum logic [1:0] {DMEM_IDLE, DMEM_BUSY, DMEM_RESP} dmem_state_t`.
- One sub-module, `dmem_sram`:
  - single-port array, parameters `DATA_WIDTH` and `DEPTH`;
  - synchronous write-enable, combinational read, no reset.
- `dmem_ctrl` holds the FSM, the request latch, the counter and the error decode.

## Test plan
- Store `addr=0x10`, `wdata=0xDEADBEEF`, then load `addr=0x10`:
  - each ack arrives exactly `LATENCY` (2) cycles after acceptance;
  - the load returns `0xDEADBEEF` with `err` = 0.
- Misaligned store `addr=0x13`:
  - ack with `err` = 1 and `rdata` = 0;
  - a subsequent load of `0x10` still returns the prior value.
- Out-of-range load `addr=0x400` (`DEPTH` = 256): ack with `err` = 1 and `rdata` = 0.
- Back-to-back, req held high: stores to `0x0`, `0x4`, `0x8` with data 1, 2, 3 produce acks every 3 cycles; loads then return 1, 2, 3.
- Reset pulse one cycle after accepting a store of `0xA5A5A5A5` to `0x20`:
  - no ack is produced;
  - a later load of `0x20` returns the previous contents.
- Random LOAD/STORE for 5000 cycles against a scoreboard memory model:
  - zero mismatches;
  - ack never high for two consecutive cycles.

Source files
------------

// File: rtl/simple_processor_pkg.sv
// Shared defaults and types for the processor's data-memory slice.
package simple_processor_pkg;

    localparam int unsigned DMEM_DEPTH   = 256;
    localparam int unsigned DMEM_LATENCY = 2;

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_BUSY,
        DMEM_RESP
    } dmem_state_t;

endpackage

// File: rtl/dmem_sram.sv
// Single-port word array: synchronous write, combinational read, no reset.
module dmem_sram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: commit on the rising edge while we is high
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Read port: asynchronous read of the addressed word
    always_comb begin
        rdata = mem[idx];
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: request latch, fixed-latency FSM, error decode
// and the single-ported word array behind it.
module dmem_ctrl
    import simple_processor_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = DMEM_DEPTH,
    parameter int unsigned LATENCY    = DMEM_LATENCY
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  dmem_req_i,
    input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic                  dmem_we_i,
    input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
    output logic [DATA_WIDTH-1:0] dmem_rdata_o,
    output logic                  dmem_ack_o,
    output logic                  dmem_err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    // BUSY lasts LATENCY-1 cycles; the counter holds the remaining extra cycles
    localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

    dmem_state_t           state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  err_q;
    logic                  ack_q;
    logic                  rsp_err_q;

    logic                  misaligned;
    logic                  out_of_range;
    logic                  req_err;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Error decode of the incoming address (only sampled on acceptance)
    always_comb begin
        misaligned   = |dmem_addr_i[1:0];
        out_of_range = |(dmem_addr_i >> (IDX_W + 2));
        req_err      = misaligned | out_of_range;
    end

    // Request FSM with latched request fields and registered ack/err
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state     <= DMEM_IDLE;
            cnt       <= '0;
            idx_q     <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            ack_q     <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            ack_q     <= 1'b0;
            rsp_err_q <= 1'b0;
            case (state)
                DMEM_IDLE: begin
                    if (dmem_req_i) begin
                        idx_q   <= dmem_addr_i[IDX_W+1:2];
                        we_q    <= dmem_we_i;
                        wdata_q <= dmem_wdata_i;
                        err_q   <= req_err;
                        if (LATENCY == 1) begin
                            state     <= DMEM_RESP;
                            ack_q     <= 1'b1;
                            rsp_err_q <= req_err;
                        end else begin
                            state <= DMEM_BUSY;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                DMEM_BUSY: begin
                    if (cnt == '0) begin
                        state     <= DMEM_RESP;
                        ack_q     <= 1'b1;
                        rsp_err_q <= err_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DMEM_RESP: begin
                    state <= DMEM_IDLE;
                end
                default: begin
                    state <= DMEM_IDLE;
                end
            endcase
        end
    end

    // Store commits at the edge ending RESP; read data is gated to good loads in RESP
    always_comb begin
        mem_we       = (state == DMEM_RESP) && we_q && !err_q;
        dmem_rdata_o = '0;
        if ((state == DMEM_RESP) && !we_q && !err_q) begin
            dmem_rdata_o = mem_rdata;
        end
    end

    assign dmem_ack_o = ack_q;
    assign dmem_err_o = rsp_err_q;

    dmem_sram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_sram (
        .clk   (clk_i),
        .we    (mem_we),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed vector table, reset abort,
// and a long random LOAD/STORE run against a scoreboard memory model.
module tb_dmem_ctrl;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    always #5 clk = ~clk;

    dmem_ctrl #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH      (256),
        .LATENCY    (LAT)
    ) dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .dmem_req_i   (req),
        .dmem_addr_i  (addr),
        .dmem_we_i    (we),
        .dmem_wdata_i (wdata),
        .dmem_rdata_o (rdata),
        .dmem_ack_o   (ack),
        .dmem_err_o   (err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
        int          gap;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    exp_t        sb[$];
    logic [31:0] model [256];
    int          n_vec = 0;
    int          n_bad = 0;
    int          acks_seen = 0;
    int          cyc = 0;
    logic        prev_ack = 1'b0;
    bit          chained = 1'b0;

    always @(posedge clk) cyc++;

    // Output monitor: pop expectation on each ack, and flag consecutive acks
    always @(negedge clk) begin : monitor
        exp_t e;
        if (ack) begin
            acks_seen++;
            n_vec++;
            if (prev_ack) begin
                n_bad++;
                $display("FAIL ack_double: ack high in two consecutive cycles at t=%0t", $time);
            end
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_ack: ack with no outstanding request at t=%0t", $time);
            end else begin
                e = sb.pop_front();
                if (rdata !== e.rdata || err !== e.err) begin
                    n_bad++;
                    $display("FAIL response: got rdata=%h err=%b, expected rdata=%h err=%b at t=%0t",
                             rdata, err, e.rdata, e.err, $time);
                end
            end
        end
        prev_ack = ack;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Drop req and wait n cycles so the next access starts from IDLE
    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) @(negedge clk);
        chained = 1'b0;
    endtask

    // Drive one access, queue its expectation, wait for ack and check latency
    task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   edges;
        int   exp_edges;
        logic bad;
        bad = (a[1:0] != 2'b00) || (a[31:10] != '0);
        if (w && !bad) model[a[9:2]] = d;
        e.rdata = exp_rd;
        e.err   = exp_err;
        sb.push_back(e);
        exp_edges = chained ? int'(LAT) + 1 : int'(LAT);
        addr  = a;
        we    = w;
        wdata = d;
        req   = 1'b1;
        for (edges = 1; edges <= 20; edges++) begin
            @(negedge clk);
            if (ack) break;
        end
        n_vec++;
        if (!ack) begin
            n_bad++;
            $display("FAIL ack_timeout: addr=%h got no ack, expected one within %0d cycles", a, exp_edges);
            sb.delete();
            req = 1'b0;
            chained = 1'b0;
        end else begin
            if (edges != exp_edges) begin
                n_bad++;
                $display("FAIL latency: addr=%h got %0d cycles, expected %0d", a, edges, exp_edges);
            end
            chained = 1'b1;
        end
    endtask

    // Random access with expectation taken from the model
    task automatic rand_access();
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
        logic        bad;
        int          r;
        r = $urandom_range(0, 15);
        if (r == 0)      a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        else if (r == 1) a = 32'h400 << $urandom_range(0, 21);
        else             a = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
        w   = 1'($urandom_range(0, 1));
        d   = $urandom;
        bad = (a[1:0] != 2'b00) || (a[31:10] != '0);
        access(a, w, d, (w || bad) ? 32'h0 : model[a[9:2]], bad);
    endtask

    vec_t vt[13];

    initial begin : main
        int a0;
        int start;

        vt[0]  = '{32'h10,       1'b1, 32'hDEADBEEF, 1, 32'h0,        1'b0};
        vt[1]  = '{32'h10,       1'b0, 32'h0,        1, 32'hDEADBEEF, 1'b0};
        vt[2]  = '{32'h13,       1'b1, 32'h12345678, 1, 32'h0,        1'b1};
        vt[3]  = '{32'h10,       1'b0, 32'h0,        0, 32'hDEADBEEF, 1'b0};
        vt[4]  = '{32'h400,      1'b0, 32'h0,        0, 32'h0,        1'b1};
        vt[5]  = '{32'h0,        1'b1, 32'h1,        2, 32'h0,        1'b0};
        vt[6]  = '{32'h4,        1'b1, 32'h2,        0, 32'h0,        1'b0};
        vt[7]  = '{32'h8,        1'b1, 32'h3,        0, 32'h0,        1'b0};
        vt[8]  = '{32'h0,        1'b0, 32'h0,        0, 32'h1,        1'b0};
        vt[9]  = '{32'h4,        1'b0, 32'h0,        0, 32'h2,        1'b0};
        vt[10] = '{32'h8,        1'b0, 32'h0,        0, 32'h3,        1'b0};
        vt[11] = '{32'h3FC,      1'b0, 32'h0,        1, 32'hC0DE00FF, 1'b0};
        vt[12] = '{32'h80000000, 1'b0, 32'h0,        0, 32'h0,        1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_ack", {31'd0, ack}, 32'h0);
        check("reset_err", {31'd0, err}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        arst = 1'b0;
        @(negedge clk);

        // Preload every word back-to-back
        for (int unsigned i = 0; i < 256; i++) begin
            access(i * 4, 1'b1, 32'hC0DE0000 | i, 32'h0, 1'b0);
        end
        idle(1);

        // Directed vectors
        for (int i = 0; i < 13; i++) begin
            if (vt[i].gap > 0) idle(vt[i].gap);
            access(vt[i].a, vt[i].w, vt[i].d, vt[i].exp_rdata, vt[i].exp_err);
        end
        idle(2);

        // Reset one cycle after accepting a store: no ack, no write
        a0    = acks_seen;
        addr  = 32'h20;
        we    = 1'b1;
        wdata = 32'hA5A5A5A5;
        req   = 1'b1;
        @(negedge clk);
        arst = 1'b1;
        req  = 1'b0;
        #1;
        check("abort_ack_in_reset", {31'd0, ack}, 32'h0);
        @(negedge clk);
        arst = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_ack", acks_seen - a0, 32'h0);
        chained = 1'b0;
        access(32'h20, 1'b0, 32'h0, 32'hC0DE0008, 1'b0);
        idle(1);

        // Random traffic
        start = cyc;
        while (cyc - start < 5000) begin
            rand_access();
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(3);
        check("scoreboard_drained", sb.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
